mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Sequencer/arbiter sharing one single-port memory between the pipelined CPU's instruction-fetch port and its data (load/store) port. It accepts one request at a time, drives the memory for a fixed number of wait cycles, and returns read data with a one-cycle ready pulse; the pipeline stalls its requesting stage until ready. Sits between the PCPU instruction/data interfaces and the unified RAM/MIO bus.

Parameters:
ADDR_W, 32, width of all address ports
DATA_W, 32, width of all data ports
WAIT_CYCLES, 1, memory access latency in cycles; legal 0..7

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, registered
if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  4  store byte enables (swlength encoding)
d_rdata  out  DATA_W  load data, registered, unextended
d_ready  out  1  one-cycle pulse: data access complete
cpu_mio  out  1  high while a data access owns the bus
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset low at a rising edge): state IDLE, last_grant = IF, wait counter 0; all outputs 0, including if_rdata/d_rdata. Reset mid-access aborts it: mem_en/mem_we drop after that edge, no ready pulse is issued, and no partial write is retried.
- States: IDLE, BUSY, RESP.
- IDLE: if exactly one of d_req/if_req is high, grant it. If both are high, grant the port not equal to last_grant (alternation). The first contention after reset goes to data. On grant: latch addr, we, wdata and be into internal registers; set owner and last_grant; load counter = WAIT_CYCLES; go to BUSY. With no request, stay in IDLE; all mem_* outputs are 0.
- BUSY: mem_en=1 and mem_addr = latched addr. For a data store: mem_we=1, mem_wdata = latched data, mem_be = latched be. For loads and fetches: mem_we=0, mem_wdata=0, mem_be=4'b1111. cpu_mio=1 iff owner is data. If counter==0, capture mem_rdata into the owner's rdata register (stores leave d_rdata unchanged) and go to RESP. Otherwise decrement the counter.
- RESP: owner's ready=1 for exactly this cycle; mem_en=0; go to IDLE. A new grant is possible only from IDLE, on the next cycle.
- Latency: a request seen in IDLE at cycle T gives BUSY for cycles T+1..T+1+WAIT_CYCLES and the ready pulse at T+2+WAIT_CYCLES. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Request inputs are sampled only in IDLE. Changes to addr/data after the grant are ignored. If a requester drops req during BUSY, the access still completes and ready still pulses. If req drops before the grant, no access occurs.
- if_ready and d_ready are never high in the same cycle. rdata registers hold their value until the next completion for that port.
- No starvation: under continuous contention, grants strictly alternate D, I, D, I.

Test Plan:
- Single fetch, WAIT_CYCLES=1, if_addr=0x100, mem returns 0x00500093: req at T → mem_en high T+1..T+2, if_ready pulse at T+3, if_rdata=0x00500093, d_ready stays 0.
- Store, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011 → mem_we=1 and mem_be=0011 only during BUSY, cpu_mio=1 over the same cycles, d_ready pulse at T+3, d_rdata unchanged.
- Both requesting continuously from reset → grant order D, I, D, I; ready pulses spaced 4 cycles apart; never both high together.
- d_addr changed from 0x10 to 0x20 one cycle after grant → mem_addr stays 0x10 throughout.
- reset driven low during BUSY of a store → next cycle all outputs 0, no d_ready; after release, a fresh d_req is served normally.
- WAIT_CYCLES=0 and WAIT_CYCLES=7 builds → ready at T+2 and T+9 respectively; captured read data equals mem_rdata from the last BUSY cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the CPU instruction-fetch port and
//   the data (load/store) port. One access is in flight at a time. Each access
//   spends WAIT_CYCLES+1 cycles driving the memory (BUSY), then one cycle
//   pulsing the owner's ready (RESP), then returns to IDLE. When both ports
//   request in IDLE, the port that did not win last time gets the grant.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   if_req/if_addr        fetch request (held until if_ready) and address
//   if_rdata/if_ready     registered fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr     data request, store select, address
//   d_wdata/d_be          store data and byte enables
//   d_rdata/d_ready       registered load data and one-cycle completion pulse
//   cpu_mio               high while a data access drives the memory
//   mem_en/mem_we         memory enable / write enable
//   mem_addr/mem_wdata    memory address / write data
//   mem_be/mem_rdata      memory byte enables / read data
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              cpu_mio,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       OWN_IF    = 1'b0;
  localparam logic       OWN_D     = 1'b1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              cpu_mio_q, cpu_mio_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              pick_d;
  logic              busy_next;
  logic              store_next;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data wins when alone, or on contention when fetch won last time.
          pick_d  = d_req && (!if_req || (last_q == OWN_IF));
          owner_d = pick_d;
          last_d  = pick_d;
          addr_d  = pick_d ? d_addr : if_addr;
          we_d    = pick_d && d_we;
          wdata_d = d_wdata;
          be_d    = d_be;
          cnt_d   = WAIT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 3'd0) begin
          // Stores return nothing, so d_rdata keeps its previous load value.
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: derive them from the state being entered.
    busy_next   = (state_d == BUSY);
    store_next  = busy_next && (owner_d == OWN_D) && we_d;
    mem_en_d    = busy_next;
    mem_we_d    = store_next;
    mem_addr_d  = busy_next ? addr_d : '0;
    mem_wdata_d = store_next ? wdata_d : '0;
    mem_be_d    = busy_next ? (store_next ? be_d : 4'b1111) : 4'b0000;
    cpu_mio_d   = busy_next && (owner_d == OWN_D);
    if_ready_d  = (state_d == RESP) && (owner_d == OWN_IF);
    d_ready_d   = (state_d == RESP) && (owner_d == OWN_D);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= OWN_IF;
      owner_q     <= OWN_IF;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= 4'b0000;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      cpu_mio_q   <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      cpu_mio_q   <= cpu_mio_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign cpu_mio   = cpu_mio_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
